// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bundles the instruction-fetch port, the data-access port and
//               the memory strobe/address/handshake signals of mem_arbiter.
//               The shared tristate data bus is kept outside as a plain net.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int WORD_SIZE = 16
);
    // Instruction-fetch requester
    logic                 i_req;
    logic [WORD_SIZE-1:0] i_addr;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_ack;
    logic                 i_err;

    // Data requester
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_ack;
    logic                 d_err;

    // Memory side
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic                 inputReady;

    // Arbiter view
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, inputReady,
        output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
        output readM, writeM, address
    );

    // Requester / memory-model view
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, inputReady,
        input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
        input  readM, writeM, address
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (instruction fetch / data) arbiter in front of a
//               single-port memory. One access in flight at a time, ties are
//               broken round-robin, and a wait counter aborts accesses whose
//               memory never signals inputReady.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 8
) (
    input  wire                 clk,
    input  wire                 reset_n,
    mem_arbiter_if.slave        bus,
    inout  wire [WORD_SIZE-1:0] data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SERVE_I = 2'd1;
    localparam logic [1:0] c_SERVE_D = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    // Value the counter holds on the last permitted wait cycle; one more
    // wait cycle makes it reach TIMEOUT, which aborts the access.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]           r_state;
    logic                 r_last_d;   // 1 = data port served last, 0 = fetch
    logic [CNT_W-1:0]     r_count;
    logic                 r_we;
    logic [WORD_SIZE-1:0] r_wdata;

    logic                 w_any_req;
    logic                 w_grant_d;

    // Arbitration: a lone requester wins outright; on a tie the port that was
    // not served last wins.
    always_comb begin
        w_any_req = bus.i_req | bus.d_req;
        w_grant_d = bus.d_req & (~bus.i_req | ~r_last_d);
    end

    // Write data reaches the shared bus only while the write strobe is up.
    assign data = bus.writeM ? r_wdata : {WORD_SIZE{1'bz}};

    // Arbiter FSM with registered strobes, address, read data and pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= c_IDLE;
            r_last_d    <= 1'b0;
            r_count     <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            bus.readM   <= 1'b0;
            bus.writeM  <= 1'b0;
            bus.address <= '0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
            bus.i_ack   <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.i_err   <= 1'b0;
            bus.d_err   <= 1'b0;
        end else begin
            // Completion pulses last a single cycle unless set below.
            bus.i_ack <= 1'b0;
            bus.d_ack <= 1'b0;
            bus.i_err <= 1'b0;
            bus.d_err <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= w_grant_d ? c_SERVE_D : c_SERVE_I;
                        r_last_d    <= w_grant_d;
                        r_count     <= '0;
                        r_we        <= w_grant_d & bus.d_we;
                        r_wdata     <= bus.d_wdata;
                        bus.address <= w_grant_d ? bus.d_addr : bus.i_addr;
                        bus.readM   <= ~(w_grant_d & bus.d_we);
                        bus.writeM  <= w_grant_d & bus.d_we;
                    end
                end

                c_SERVE_I, c_SERVE_D: begin
                    if (bus.inputReady) begin
                        // Reads capture the bus; writes leave read data alone.
                        if (!r_we) begin
                            if (r_state == c_SERVE_D) begin
                                bus.d_rdata <= data;
                            end else begin
                                bus.i_rdata <= data;
                            end
                        end
                        bus.i_ack  <= (r_state == c_SERVE_I);
                        bus.d_ack  <= (r_state == c_SERVE_D);
                        bus.readM  <= 1'b0;
                        bus.writeM <= 1'b0;
                        r_state    <= c_DONE;
                    end else if (r_count == c_CNT_LAST) begin
                        bus.i_err  <= (r_state == c_SERVE_I);
                        bus.d_err  <= (r_state == c_SERVE_D);
                        bus.readM  <= 1'b0;
                        bus.writeM <= 1'b0;
                        r_state    <= c_DONE;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end

                c_DONE: begin
                    // One dead cycle between accesses; inputReady ignored.
                    r_state <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A transaction-level model
//               (grant choice, memory contents, expected read words) predicts
//               every strobe, pulse and read word, under directed and random
//               requests, memory latencies and timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int WORD_SIZE = 16;
    localparam int TIMEOUT   = 8;

    logic clk = 1'b0;
    logic reset_n;

    mem_arbiter_if #(.WORD_SIZE(WORD_SIZE)) bus ();

    wire  [WORD_SIZE-1:0] data;
    logic                 mem_oe;
    logic [WORD_SIZE-1:0] mem_val;

    assign data = mem_oe ? mem_val : {WORD_SIZE{1'bz}};

    mem_arbiter #(.WORD_SIZE(WORD_SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .data    (data)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [WORD_SIZE-1:0] mem [0:255];
    bit                   exp_last_d;
    logic [WORD_SIZE-1:0] exp_i_rdata;
    logic [WORD_SIZE-1:0] exp_d_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one arbitration round. Entered at a falling edge with the DUT idle
    // and at least one request raised; returns at the falling edge of the
    // following idle cycle. lat = strobe cycles before inputReady (lat >=
    // TIMEOUT means the memory never answers).
    task automatic serve(input int lat, input bit drop_mid, input bit keep, output bit obs_d);
        bit                   g_d, g_we, g_ok;
        logic [WORD_SIZE-1:0] g_addr, g_wd, word;

        g_d    = bus.d_req && (!bus.i_req || !exp_last_d);
        g_addr = g_d ? bus.d_addr : bus.i_addr;
        g_we   = g_d && bus.d_we;
        g_wd   = bus.d_wdata;
        g_ok   = (lat < TIMEOUT);
        word   = mem[g_addr[7:0]];

        @(negedge clk);
        // Requester inputs after the grant must not matter.
        bus.i_addr  = 16'($urandom);
        bus.d_addr  = 16'($urandom);
        bus.d_wdata = 16'($urandom);
        if (drop_mid) begin
            if (g_d) bus.d_req = 1'b0;
            else     bus.i_req = 1'b0;
        end

        for (int n = 0; n < TIMEOUT; n++) begin
            if (n > 0) @(negedge clk);
            bus.inputReady = 1'b0;
            mem_oe         = 1'b0;
            check("strobe_addr", {bus.readM, bus.writeM, bus.address}, {!g_we, g_we, g_addr});
            if (g_we) check("wr_data", data, g_wd);
            check("early_pulse", {bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 4'b0000);
            if (g_ok && n == lat) begin
                bus.inputReady = 1'b1;
                if (!g_we) begin
                    mem_oe  = 1'b1;
                    mem_val = word;
                end
                break;
            end
        end

        @(negedge clk);
        // DONE cycle: update model, check pulses, then drive junk memory
        // activity that must be ignored.
        if (g_ok) begin
            if (g_we)     mem[g_addr[7:0]] = g_wd;
            else if (g_d) exp_d_rdata = word;
            else          exp_i_rdata = word;
        end
        exp_last_d = g_d;
        obs_d      = bus.d_ack | bus.d_err;
        check("done_strobes", {bus.readM, bus.writeM}, 2'b00);
        check("done_pulses", {bus.i_ack, bus.d_ack, bus.i_err, bus.d_err},
              {!g_d && g_ok, g_d && g_ok, !g_d && !g_ok, g_d && !g_ok});
        check("i_rdata", bus.i_rdata, exp_i_rdata);
        check("d_rdata", bus.d_rdata, exp_d_rdata);
        if (!keep) begin
            if (g_d) bus.d_req = 1'b0;
            else     bus.i_req = 1'b0;
        end
        bus.inputReady = 1'b1;
        mem_oe         = 1'b1;
        mem_val        = 16'($urandom);

        @(negedge clk);
        mem_oe = 1'b0;
        check("idle_state", {bus.readM, bus.writeM, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 6'b0);
        check("idle_rdata", {bus.i_rdata, bus.d_rdata}, {exp_i_rdata, exp_d_rdata});
        bus.inputReady = 1'($urandom);
    endtask

    initial begin
        bit obs_d;

        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        exp_last_d     = 1'b0;
        exp_i_rdata    = '0;
        exp_d_rdata    = '0;
        mem_oe         = 1'b0;
        mem_val        = '0;
        reset_n        = 1'b0;
        bus.i_req      = 1'b0;
        bus.i_addr     = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.inputReady = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out", {bus.readM, bus.writeM, bus.address, bus.i_rdata, bus.d_rdata,
                            bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Simultaneous requests right after reset: D first, then I
        bus.i_req = 1'b1; bus.i_addr = 16'h0041;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0042;
        serve(1, 1'b0, 1'b0, obs_d);
        check("tie_first_d", obs_d, 1'b1);
        serve(0, 1'b0, 1'b0, obs_d);
        check("tie_then_i", obs_d, 1'b0);

        // Both held continuously: grants alternate D,I,D,I,D,I
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            serve(k % 3, 1'b0, 1'b1, obs_d);
            check("alternate", obs_d, (k % 2) == 0);
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);

        // Fetch from 0x0010 returning 0x6A01
        mem[8'h10] = 16'h6A01;
        bus.i_req = 1'b1; bus.i_addr = 16'h0010;
        serve(2, 1'b0, 1'b0, obs_d);
        check("fetch_word", bus.i_rdata, 16'h6A01);

        // Write 0x1234 to 0x0020, then read it back
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0020; bus.d_wdata = 16'h1234;
        serve(1, 1'b0, 1'b0, obs_d);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
        serve(0, 1'b0, 1'b0, obs_d);
        check("readback", bus.d_rdata, 16'h1234);

        // Read that times out, then a normal read; also ready on last wait cycle
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0030;
        serve(TIMEOUT, 1'b0, 1'b0, obs_d);
        check("timeout_keep", bus.d_rdata, 16'h1234);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0031;
        serve(TIMEOUT - 1, 1'b0, 1'b0, obs_d);
        bus.i_req = 1'b1; bus.i_addr = 16'h0032;
        serve(TIMEOUT + 3, 1'b1, 1'b0, obs_d);

        // Reset while a fetch strobe is up, with the memory answering
        bus.i_req = 1'b1; bus.i_addr = 16'h0050;
        @(negedge clk);
        check("pre_reset_rd", {bus.readM, bus.writeM}, 2'b10);
        reset_n        = 1'b0;
        bus.i_req      = 1'b0;
        bus.inputReady = 1'b1;
        mem_oe         = 1'b1;
        mem_val        = 16'hBEEF;
        @(negedge clk);
        check("mid_reset", {bus.readM, bus.writeM, bus.address, bus.i_rdata, bus.d_rdata,
                            bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 0);
        reset_n        = 1'b1;
        bus.inputReady = 1'b0;
        mem_oe         = 1'b0;
        exp_last_d     = 1'b0;
        exp_i_rdata    = '0;
        exp_d_rdata    = '0;
        @(negedge clk);
        check("post_reset", {bus.readM, bus.writeM, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err}, 6'b0);

        // Random traffic
        for (int r = 0; r < 60; r++) begin
            if (!bus.i_req && $urandom_range(0, 1) == 1) begin
                bus.i_req  = 1'b1;
                bus.i_addr = 16'($urandom_range(0, 15));
            end
            if (!bus.d_req && $urandom_range(0, 1) == 1) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom);
                bus.d_addr  = 16'($urandom_range(0, 15));
                bus.d_wdata = 16'($urandom);
            end
            if (!bus.i_req && !bus.d_req) begin
                bus.i_req  = 1'b1;
                bus.i_addr = 16'($urandom_range(0, 15));
            end
            serve(int'($urandom_range(0, TIMEOUT + 1)), $urandom_range(0, 3) == 0, 1'b0, obs_d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, width of address and data words.
REQ-002 Parameter TIMEOUT, default 8, max cycles waiting for inputReady before abort.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 i_req  input  1  instruction-fetch read request, held until i_ack or i_err.
REQ-006 i_addr  input  WORD_SIZE  fetch address.
REQ-007 i_rdata  output  WORD_SIZE  fetched word, registered.
REQ-008 i_ack  output  1  one-cycle pulse, fetch complete.
REQ-009 d_req  input  1  data access request, held until d_ack or d_err.
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  WORD_SIZE  data address.
REQ-012 d_wdata  input  WORD_SIZE  write data.
REQ-013 d_rdata  output  WORD_SIZE  read word, registered.
REQ-014 d_ack  output  1  one-cycle pulse, data access complete.
REQ-015 i_err, d_err  output  1 each  one-cycle pulse, access aborted by timeout.
REQ-016 readM  output  1  memory read strobe.
REQ-017 writeM  output  1  memory write strobe.
REQ-018 address  output  WORD_SIZE  memory address.
REQ-019 data  inout  WORD_SIZE  shared memory data bus.
REQ-020 inputReady  input  1  memory completion: read data valid or write accepted.

Function
REQ-021 FSM states IDLE, SERVE_I, SERVE_D, DONE; single memory access in flight at any time.
REQ-022 IDLE: no request -> stay; only i_req -> SERVE_I; only d_req -> SERVE_D.
REQ-023 IDLE, both requests: grant the requester not served last (last_grant bit); after reset last_grant = I, so D wins first tie.
REQ-024 On grant edge: latch address, d_we and d_wdata into internal registers; update last_grant; clear timeout counter.
REQ-025 readM/writeM/address are registered outputs: asserted throughout SERVE_x starting the cycle after the grant edge; readM=1 in SERVE_I and SERVE_D read; writeM=1 only in SERVE_D write; never both 1.
REQ-026 data driven with latched write word only while writeM=1; otherwise high-Z.
REQ-027 SERVE_x, inputReady=1: capture data into i_rdata/d_rdata (reads only; writes leave d_rdata unchanged), pulse matching ack next cycle, -> DONE.
REQ-028 DONE: strobes deasserted, ack high for exactly this cycle; -> IDLE next edge; new grant at earliest one cycle after DONE.
REQ-029 Latency, no contention: request seen at edge N -> strobe from N+1 -> inputReady at cycle k -> ack during cycle k+1.
REQ-030 SERVE_x: counter increments each cycle inputReady=0; reaching TIMEOUT -> pulse matching err, no ack, rdata unchanged, -> DONE.
REQ-031 Request deasserted mid-access: access still completes; ack/err still pulsed.
REQ-032 inputReady in IDLE or DONE ignored.
REQ-033 Address and write data use latched values; requester input changes after grant have no effect.

Reset
REQ-034 reset_n=0 at a rising edge: state IDLE, readM=0, writeM=0, data high-Z, address=0, i_rdata=d_rdata=0, all ack/err=0, last_grant=I, counter=0.
REQ-035 Reset mid-access aborts without ack/err; strobes low the cycle after the reset edge.

Verification
REQ-036 i_req, i_addr=0x0010, memory returns 0x6A01 after 2 cycles -> readM with address 0x0010, i_rdata=0x6A01, single i_ack, d_ack=0.
REQ-037 d_req write d_addr=0x0020 d_wdata=0x1234 -> writeM=1, data=0x1234, readM=0, single d_ack; data high-Z afterwards.
REQ-038 i_req and d_req together after reset, both held -> D served first, then I; two acks, strobes never overlap.
REQ-039 Both requests held continuously for 6 accesses -> grants alternate D,I,D,I,D,I.
REQ-040 d_req read, inputReady held 0 -> d_err pulses after exactly 8 wait cycles, no d_ack, d_rdata unchanged; next request served normally.
REQ-041 reset_n=0 while readM=1 -> strobes 0, no ack, all outputs at REQ-034 values.
